// File: rtl/fft_fundamental_search_pkg.sv
// Shared constants and state encoding for the FFT fundamental search.
// INDEX_WIDTH and FRAME_BINS are reused by the THD harmonic-capture block.
package fft_fundamental_search_pkg;

   localparam int FFT_INDEX_WIDTH  = 11;
   localparam int FFT_FRAME_BINS   = 1024;
   localparam int FFT_SEARCH_START = 2;
   localparam int FFT_SEARCH_END   = 1000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_HARM = 2'd2
   } fs_state_t;

endpackage

// File: rtl/fft_fundamental_search_harm_index_gen.sv
// Harmonic index generator: repeated add of base k, clamped to the frame.
// Ports: clk, rst_n, i_load/i_base (latch k), i_step (one add per cycle),
//        o_h2..o_h4 registered, o_h5 combinational (valid on 4th step).
module fft_fundamental_search_harm_index_gen #(
   parameter int INDEX_WIDTH = 11,
   parameter int FRAME_BINS  = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_load,
   input  logic                   i_step,
   input  logic [INDEX_WIDTH-1:0] i_base,
   output logic [INDEX_WIDTH-1:0] o_h2,
   output logic [INDEX_WIDTH-1:0] o_h3,
   output logic [INDEX_WIDTH-1:0] o_h4,
   output logic [INDEX_WIDTH-1:0] o_h5
);

   localparam int AW = INDEX_WIDTH + 3;
   localparam logic [AW-1:0] LP_LIMIT = AW'(FRAME_BINS);

   logic [AW-1:0]          r_acc;
   logic [AW-1:0]          r_base;
   logic [1:0]             r_cnt;
   logic [INDEX_WIDTH-1:0] r_h2;
   logic [INDEX_WIDTH-1:0] r_h3;
   logic [INDEX_WIDTH-1:0] r_h4;
   logic [AW-1:0]          w_sum;
   logic [INDEX_WIDTH-1:0] w_clamp;

   assign w_sum   = r_acc + r_base;
   // Harmonics falling outside the frame are reported as bin 0.
   assign w_clamp = (w_sum >= LP_LIMIT) ? '0 : w_sum[INDEX_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_base <= '0;
         r_cnt  <= '0;
         r_h2   <= '0;
         r_h3   <= '0;
         r_h4   <= '0;
      end else if (i_load) begin
         r_acc  <= {3'b000, i_base};
         r_base <= {3'b000, i_base};
         r_cnt  <= '0;
      end else if (i_step) begin
         r_acc <= w_sum;
         r_cnt <= r_cnt + 2'd1;
         case (r_cnt)
            2'd0:    r_h2 <= w_clamp;
            2'd1:    r_h3 <= w_clamp;
            2'd2:    r_h4 <= w_clamp;
            default: ;
         endcase
      end
   end

   assign o_h2 = r_h2;
   assign o_h3 = r_h3;
   assign o_h4 = r_h4;
   assign o_h5 = w_clamp;

endmodule

// File: rtl/fft_fundamental_search.sv
// Scans one magnitude frame for the peak bin in a window, reports it with
// harmonics 2..5. Ports: clk, rst_n, mag_valid/mag_data/mag_index in;
// fund_valid, fund_index, fund_mag, harm2..5_index, fund_mag_lo/hi,
// no_signal, frame_err, busy out. Option macro: FUND_NEIGHBOR_EN.
module fft_fundamental_search
   import fft_fundamental_search_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    INDEX_WIDTH  = FFT_INDEX_WIDTH,
   parameter int                    FRAME_BINS   = FFT_FRAME_BINS,
   parameter int                    SEARCH_START = FFT_SEARCH_START,
   parameter int                    SEARCH_END   = FFT_SEARCH_END,
   parameter logic [DATA_WIDTH-1:0] MIN_LEVEL    = DATA_WIDTH'(1000)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mag_valid,
   input  logic [DATA_WIDTH-1:0]  mag_data,
   input  logic [INDEX_WIDTH-1:0] mag_index,
   output logic                   fund_valid,
   output logic [INDEX_WIDTH-1:0] fund_index,
   output logic [DATA_WIDTH-1:0]  fund_mag,
   output logic [INDEX_WIDTH-1:0] harm2_index,
   output logic [INDEX_WIDTH-1:0] harm3_index,
   output logic [INDEX_WIDTH-1:0] harm4_index,
   output logic [INDEX_WIDTH-1:0] harm5_index,
   output logic [DATA_WIDTH-1:0]  fund_mag_lo,
   output logic [DATA_WIDTH-1:0]  fund_mag_hi,
   output logic                   no_signal,
   output logic                   frame_err,
   output logic                   busy
);

   localparam logic [INDEX_WIDTH-1:0] LP_LAST  = INDEX_WIDTH'(FRAME_BINS - 1);
   localparam logic [INDEX_WIDTH-1:0] LP_START = INDEX_WIDTH'(SEARCH_START);
   localparam logic [INDEX_WIDTH-1:0] LP_END   = INDEX_WIDTH'(SEARCH_END);

   fs_state_t              r_state;
   logic [INDEX_WIDTH-1:0] r_exp;
   logic [DATA_WIDTH-1:0]  r_max;
   logic [INDEX_WIDTH-1:0] r_max_idx;
   logic [1:0]             r_hcnt;
   logic                   r_fund_valid;
   logic [INDEX_WIDTH-1:0] r_fund_index;
   logic [DATA_WIDTH-1:0]  r_fund_mag;
   logic [INDEX_WIDTH-1:0] r_h2;
   logic [INDEX_WIDTH-1:0] r_h3;
   logic [INDEX_WIDTH-1:0] r_h4;
   logic [INDEX_WIDTH-1:0] r_h5;
   logic                   r_no_signal;
   logic                   r_frame_err;

   logic                   w_mismatch;
   logic                   w_start;
   logic                   w_accept;
   logic                   w_take;
   logic [DATA_WIDTH-1:0]  w_cur_max;
   logic                   w_in_win;
   logic                   w_newmax;
   logic [INDEX_WIDTH-1:0] w_idx_nxt;
   logic                   w_last;
   logic                   w_fire;
   logic                   w_quiet;
   logic [INDEX_WIDTH-1:0] w_h2;
   logic [INDEX_WIDTH-1:0] w_h3;
   logic [INDEX_WIDTH-1:0] w_h4;
   logic [INDEX_WIDTH-1:0] w_h5;

   assign w_mismatch = (r_state == S_SCAN) && mag_valid && (mag_index != r_exp);
   // A frame begins on bin 0 from IDLE, or on a bin 0 that breaks a scan.
   assign w_start    = mag_valid && (mag_index == '0) &&
                       ((r_state == S_IDLE) || w_mismatch);
   assign w_accept   = (r_state == S_SCAN) && mag_valid && !w_mismatch;
   assign w_take     = w_start || w_accept;
   assign w_cur_max  = w_start ? '0 : r_max;
   assign w_in_win   = (mag_index >= LP_START) && (mag_index <= LP_END);
   assign w_newmax   = w_take && w_in_win && (mag_data > w_cur_max);
   assign w_idx_nxt  = w_newmax ? mag_index : (w_start ? '0 : r_max_idx);
   assign w_last     = w_accept && (mag_index == LP_LAST);
   assign w_fire     = (r_state == S_HARM) && (r_hcnt == 2'd3);
   assign w_quiet    = r_max < MIN_LEVEL;

   // Base k is taken from the next-state max so a peak on the last bin counts.
   fft_fundamental_search_harm_index_gen #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .FRAME_BINS  (FRAME_BINS)
   ) u_harm (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_last),
      .i_step (r_state == S_HARM),
      .i_base (w_idx_nxt),
      .o_h2   (w_h2),
      .o_h3   (w_h3),
      .o_h4   (w_h4),
      .o_h5   (w_h5)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_exp        <= '0;
         r_max        <= '0;
         r_max_idx    <= '0;
         r_hcnt       <= '0;
         r_fund_valid <= 1'b0;
         r_fund_index <= '0;
         r_fund_mag   <= '0;
         r_h2         <= '0;
         r_h3         <= '0;
         r_h4         <= '0;
         r_h5         <= '0;
         r_no_signal  <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_fund_valid <= 1'b0;
         r_frame_err  <= w_mismatch;
         if (w_take) begin
            r_exp <= mag_index + 1'b1;
         end
         if (w_newmax) begin
            r_max     <= mag_data;
            r_max_idx <= mag_index;
         end else if (w_start) begin
            r_max     <= '0;
            r_max_idx <= '0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_last) begin
                  r_state <= S_HARM;
                  r_hcnt  <= '0;
               end else if (w_mismatch && !w_start) begin
                  r_state <= S_IDLE;
               end
            end
            S_HARM: begin
               r_hcnt <= r_hcnt + 2'd1;
               if (w_fire) begin
                  r_state      <= S_IDLE;
                  r_fund_valid <= 1'b1;
                  r_no_signal  <= w_quiet;
                  r_fund_index <= w_quiet ? '0 : r_max_idx;
                  r_fund_mag   <= w_quiet ? '0 : r_max;
                  r_h2         <= w_quiet ? '0 : w_h2;
                  r_h3         <= w_quiet ? '0 : w_h3;
                  r_h4         <= w_quiet ? '0 : w_h4;
                  r_h5         <= w_quiet ? '0 : w_h5;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef FUND_NEIGHBOR_EN
   logic [DATA_WIDTH-1:0] r_prev;
   logic [DATA_WIDTH-1:0] r_cand_lo;
   logic [DATA_WIDTH-1:0] r_cand_hi;
   logic                  r_pend;
   logic [DATA_WIDTH-1:0] r_lo;
   logic [DATA_WIDTH-1:0] r_hi;

   // lo comes from the history register; hi is captured from the bin after k.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev    <= '0;
         r_cand_lo <= '0;
         r_cand_hi <= '0;
         r_pend    <= 1'b0;
         r_lo      <= '0;
         r_hi      <= '0;
      end else begin
         if (w_take) begin
            r_prev <= mag_data;
            if (w_newmax) begin
               r_cand_lo <= (w_start || mag_index == '0) ? '0 : r_prev;
               r_cand_hi <= '0;
               r_pend    <= 1'b1;
            end else if (w_start) begin
               r_cand_lo <= '0;
               r_cand_hi <= '0;
               r_pend    <= 1'b0;
            end else if (r_pend) begin
               r_cand_hi <= mag_data;
               r_pend    <= 1'b0;
            end
         end
         if (w_fire) begin
            r_lo   <= w_quiet ? '0 : r_cand_lo;
            r_hi   <= w_quiet ? '0 : r_cand_hi;
            r_pend <= 1'b0;
         end
      end
   end

   assign fund_mag_lo = r_lo;
   assign fund_mag_hi = r_hi;
`else
   assign fund_mag_lo = '0;
   assign fund_mag_hi = '0;
`endif

   assign fund_valid  = r_fund_valid;
   assign fund_index  = r_fund_index;
   assign fund_mag    = r_fund_mag;
   assign harm2_index = r_h2;
   assign harm3_index = r_h3;
   assign harm4_index = r_h4;
   assign harm5_index = r_h5;
   assign no_signal   = r_no_signal;
   assign frame_err   = r_frame_err;
   assign busy        = (r_state != S_IDLE);

endmodule
